fp16_sub: RTL and testbench

FP16_SUB -- requirements
Module: fp16_sub

---
 rtl/fp16_sub.sv | 223 ++++++++++++++++++++++
 tb/tb_fp16_sub.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fp16_sub.sv
// fp16_sub: pipelined IEEE 754 binary16 subtractor (result = a - b).
// An operand register feeds three compute stages: S1 unpack/specials/compare/align,
// S2 magnitude add/subtract, S3 normalize/round/pack into the output register.
// Round-to-nearest-even; denormals handled on inputs and outputs.
//
// Handshake: an operand pair transfers on a rising edge where in_valid && in_ready.
// A result transfers on a rising edge where out_valid && out_ready.
// stall = out_valid && !out_ready freezes every stage; in_ready = !stall (forced high in reset).
module fp16_sub #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       out_flags
);

    logic stall;
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst_n | ~stall;

    // operand register
    logic        v0;
    logic [15:0] a0, b0;

    // S1 combinational signals
    logic        sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
    logic        c1_special, swap, c1_sign, c1_sub;
    logic [15:0] c1_spec_res;
    logic [2:0]  c1_spec_flags;
    logic [14:0] mag_big, mag_small;
    logic [4:0]  e_big, e_small, diff;
    logic [3:0]  shamt;
    logic [10:0] sig_big, sig_small;
    logic [26:0] shifted;

    // S1 register
    logic        v1, s1_sign, s1_sub, s1_special;
    logic [4:0]  s1_exp;
    logic [13:0] s1_x, s1_y;
    logic [15:0] s1_spec_res;
    logic [2:0]  s1_spec_flags;

    // S2 register
    logic        v2, s2_sign, s2_sub, s2_special;
    logic [4:0]  s2_exp;
    logic [14:0] s2_sum;
    logic [15:0] s2_spec_res;
    logic [2:0]  s2_spec_flags;

    // S3 combinational signals
    logic [3:0]  lz;
    logic [13:0] norm, norm2;
    logic [6:0]  nexp, rsh;
    logic [27:0] den;
    logic [5:0]  ef, oe;
    logic [9:0]  om;
    logic        inc, inexact;
    logic [11:0] rnd;
    logic [15:0] c3_res;
    logic [2:0]  c3_flags;

    // capture accepted operands; a bubble is captured as valid=0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0 <= 1'b0;
        end else if (!stall) begin
            v0 <= in_valid;
            a0 <= a;
            b0 <= b;
        end
    end

    // S1: unpack, resolve specials, order by magnitude, align smaller operand with G/R/S
    always_comb begin
        sa     = a0[15];
        sb     = ~b0[15];
        a_nan  = (a0[14:10] == 5'h1F) && (a0[9:0] != 10'd0);
        b_nan  = (b0[14:10] == 5'h1F) && (b0[9:0] != 10'd0);
        a_snan = a_nan && !a0[9];
        b_snan = b_nan && !b0[9];
        a_inf  = (a0[14:10] == 5'h1F) && (a0[9:0] == 10'd0);
        b_inf  = (b0[14:10] == 5'h1F) && (b0[9:0] == 10'd0);

        c1_special    = 1'b1;
        c1_spec_res   = 16'h7E00;
        c1_spec_flags = 3'b000;
        if (a_nan || b_nan) begin
            c1_spec_flags = {a_snan | b_snan, 2'b00};
        end else if (a_inf && b_inf) begin
            if (a0[15] == b0[15]) c1_spec_flags = 3'b100;
            else                  c1_spec_res   = a0;
        end else if (a_inf) begin
            c1_spec_res = a0;
        end else if (b_inf) begin
            c1_spec_res = {~b0[15], b0[14:0]};
        end else begin
            c1_special = 1'b0;
        end

        swap      = b0[14:0] > a0[14:0];
        mag_big   = swap ? b0[14:0] : a0[14:0];
        mag_small = swap ? a0[14:0] : b0[14:0];
        c1_sign   = swap ? sb : sa;
        c1_sub    = sa ^ sb;
        // denormals use exponent 1 with a hidden bit of 0
        e_big     = (mag_big[14:10] == 5'd0) ? 5'd1 : mag_big[14:10];
        e_small   = (mag_small[14:10] == 5'd0) ? 5'd1 : mag_small[14:10];
        sig_big   = {|mag_big[14:10], mag_big[9:0]};
        sig_small = {|mag_small[14:10], mag_small[9:0]};
        diff      = e_big - e_small;
        shamt     = (diff > 5'd14) ? 4'd14 : diff[3:0];
        shifted   = {sig_small, 16'd0} >> shamt;
    end

    // S1 register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (!stall) begin
            v1            <= v0;
            s1_sign       <= c1_sign;
            s1_sub        <= c1_sub;
            s1_exp        <= e_big;
            s1_x          <= {sig_big, 3'b000};
            s1_y          <= {shifted[26:14], |shifted[13:0]};
            s1_special    <= c1_special;
            s1_spec_res   <= c1_spec_res;
            s1_spec_flags <= c1_spec_flags;
        end
    end

    // S2: magnitude add or subtract; |x| >= |y| so the difference never goes negative
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2 <= 1'b0;
        end else if (!stall) begin
            v2            <= v1;
            s2_sum        <= s1_sub ? ({1'b0, s1_x} - {1'b0, s1_y}) : ({1'b0, s1_x} + {1'b0, s1_y});
            s2_sign       <= s1_sign;
            s2_sub        <= s1_sub;
            s2_exp        <= s1_exp;
            s2_special    <= s1_special;
            s2_spec_res   <= s1_spec_res;
            s2_spec_flags <= s1_spec_flags;
        end
    end

    // S3: normalize, denormalize when exponent <= 0, round to nearest even, pack
    always_comb begin
        lz = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (s2_sum[i]) lz = 4'(13 - i);
        end
        if (s2_sum[14]) begin
            norm = {s2_sum[14:2], |s2_sum[1:0]};
            nexp = {2'b00, s2_exp} + 7'd1;
        end else begin
            norm = s2_sum[13:0] << lz;
            nexp = {2'b00, s2_exp} - {3'b000, lz};
        end
        rsh = 7'd1 - nexp;
        den = {norm, 14'd0} >> rsh;
        if (nexp[6] || (nexp == 7'd0)) begin
            norm2 = {den[27:15], |den[14:0]};
            ef    = 6'd0;
        end else begin
            norm2 = norm;
            ef    = nexp[5:0];
        end
        inexact = |norm2[2:0];
        inc     = norm2[2] & (norm2[1] | norm2[0] | norm2[3]);
        rnd     = {1'b0, norm2[13:3]} + {11'd0, inc};
        if (ef == 6'd0) begin
            // a denormal that rounds up to 0x0400 becomes the smallest normal
            oe = {5'd0, rnd[10]};
            om = rnd[9:0];
        end else if (rnd[11]) begin
            oe = ef + 6'd1;
            om = rnd[10:1];
        end else begin
            oe = ef;
            om = rnd[9:0];
        end

        if (s2_special) begin
            c3_res   = s2_spec_res;
            c3_flags = s2_spec_flags;
        end else if (s2_sum == 15'd0) begin
            // only two zeros with matching effective sign can give -0
            c3_res   = {s2_sign & ~s2_sub, 15'd0};
            c3_flags = 3'b000;
        end else if (oe >= 6'd31) begin
            c3_res   = {s2_sign, 5'h1F, 10'd0};
            c3_flags = 3'b011;
        end else begin
            c3_res   = {s2_sign, oe[4:0], om};
            c3_flags = {2'b00, inexact};
        end
    end

    // output register; result and flags hold while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= 16'h0000;
            out_flags <= 3'b000;
        end else if (!stall) begin
            out_valid <= v2;
            if (v2) begin
                result    <= c3_res;
                out_flags <= c3_flags;
            end
        end
    end

endmodule

// File: tb/tb_fp16_sub.sv
// tb_fp16_sub: vector table plus directed sequences for fp16_sub, scoreboard on a queue.
module tb_fp16_sub;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, result;
    logic [2:0]  out_flags;

    always #5 clk = ~clk;

    fp16_sub #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_flags(out_flags)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [2:0]  flags;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    int total = 0;
    int bad   = 0;
    logic [18:0] exp_q[$];
    int stall_seen = 0;
    int out_seen   = 0;
    logic        held_valid = 1'b0;
    logic [15:0] held_res;
    logic [2:0]  held_flags;
    logic        bp_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    // scoreboard / monitor, sampled on the falling edge
    always @(negedge clk) begin
        logic [18:0] e;
        if (rst_n) begin
            if (held_valid) begin
                check("stall_hold_valid", out_valid, 1);
                check("stall_hold_result", result, held_res);
                check("stall_hold_flags", out_flags, held_flags);
            end
            held_valid = 1'b0;
            if (out_valid) out_seen++;
            if (out_valid && !out_ready) begin
                stall_seen++;
                check("in_ready_stall", in_ready, 0);
                held_valid = 1'b1;
                held_res   = result;
                held_flags = out_flags;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h/%b want none", result, out_flags);
                end else begin
                    e = exp_q.pop_front();
                    check("result", result, e[18:3]);
                    check("flags", out_flags, e[2:0]);
                end
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    // present one operand pair; push its expectation once acceptance is certain
    task automatic send(input vec_t v);
        int n = 0;
        a = v.a;
        b = v.b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%b want 1", in_ready);
        end else begin
            exp_q.push_back({v.res, v.flags});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        vecs[0]  = '{16'h4200, 16'h3C00, 16'h4000, 3'b000};
        vecs[1]  = '{16'h3C01, 16'h9000, 16'h3C02, 3'b001};
        vecs[2]  = '{16'h3C00, 16'h8C00, 16'h3C00, 3'b001};
        vecs[3]  = '{16'h7C00, 16'h7C00, 16'h7E00, 3'b100};
        vecs[4]  = '{16'h7BFF, 16'hFBFF, 16'h7C00, 3'b011};
        vecs[5]  = '{16'h3C00, 16'h3C00, 16'h0000, 3'b000};
        vecs[6]  = '{16'h8000, 16'h0000, 16'h8000, 3'b000};
        vecs[7]  = '{16'h0400, 16'h0001, 16'h03FF, 3'b000};
        vecs[8]  = '{16'h0001, 16'h0002, 16'h8001, 3'b000};
        vecs[9]  = '{16'h0000, 16'h8000, 16'h0000, 3'b000};
        vecs[10] = '{16'h7C00, 16'h3C00, 16'h7C00, 3'b000};
        vecs[11] = '{16'h3C00, 16'hFC00, 16'h7C00, 3'b000};
        vecs[12] = '{16'h7C01, 16'h3C00, 16'h7E00, 3'b100};
        vecs[13] = '{16'h7E00, 16'h3C00, 16'h7E00, 3'b000};
        vecs[14] = '{16'h7C00, 16'hFC00, 16'h7C00, 3'b000};
        vecs[15] = '{16'h3C00, 16'h4000, 16'hBC00, 3'b000};
        vecs[16] = '{16'h0200, 16'h8200, 16'h0400, 3'b000};
        vecs[17] = '{16'h3C00, 16'h0001, 16'h3C00, 3'b001};
        vecs[18] = '{16'h3C00, 16'h1000, 16'h3BFF, 3'b000};
        vecs[19] = '{16'h7BFF, 16'hCC00, 16'h7C00, 3'b011};
        vecs[20] = '{16'hBC00, 16'h3C00, 16'hC000, 3'b000};
        vecs[21] = '{16'h7E00, 16'h7D00, 16'h7E00, 3'b100};

        // reset
        rst_n = 1'b0; in_valid = 1'b0; a = 16'h0; b = 16'h0; out_ready = 1'b1;
        @(negedge clk);
        check("in_ready_in_reset", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_result", result, 16'h0000);
        check("reset_flags", out_flags, 3'b000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // latency from acceptance edge to out_valid
        send(vecs[0]);
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_edges", n, 3);
        drain();

        // table, back-to-back, no backpressure
        for (int i = 0; i < NV; i++) send(vecs[i]);
        drain();

        // table again under random backpressure
        bp_done = 1'b0;
        fork
            begin
                for (int i = 0; i < NV; i++) send(vecs[(i * 7) % NV]);
                bp_done = 1'b1;
            end
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // directed stall: 5 ops streamed, out_ready low for 4 cycles mid-stream
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(vecs[i]);
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_cycles", stall_seen, 4);

        // reset with three ops in flight; in_valid held high during reset
        for (int i = 0; i < 3; i++) send(vecs[i + 15]);
        rst_n = 1'b0;
        in_valid = 1'b1;
        a = 16'h4200;
        b = 16'h3C00;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("midreset_out_valid", out_valid, 0);
        check("midreset_result", result, 16'h0000);
        check("midreset_flags", out_flags, 3'b000);
        check("midreset_in_ready", in_ready, 1);
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_seen = 0;
        repeat (12) @(posedge clk);
        #1;
        check("no_output_after_reset", out_seen, 0);

        // recovery after reset
        send(vecs[8]);
        drain();

        check("final_queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
